// File: rtl/expr_pkg.sv
// Shared state encoding and ASCII constants for the streaming expression evaluator.
package expr_pkg;
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_NUM  = 2'd1,
    S_OP   = 2'd2,
    S_ERR  = 2'd3
  } state_t;

  localparam logic [7:0] CH_0     = 8'h30;
  localparam logic [7:0] CH_9     = 8'h39;
  localparam logic [7:0] CH_PLUS  = 8'h2B;
  localparam logic [7:0] CH_MUL   = 8'h2A;
  localparam logic [7:0] CH_MINUS = 8'h2D;
endpackage

// File: rtl/expr_char_class.sv
// Combinational ASCII classifier. The minus detector exists only when EXPR_SUB_EN is defined.
module expr_char_class
  import expr_pkg::*;
(
  input  logic [7:0] ch,
  output logic       is_digit,
  output logic       is_plus,
  output logic       is_mul,
  output logic       is_minus,
  output logic [3:0] digit
);
  assign is_digit = (ch >= CH_0) && (ch <= CH_9);
  assign is_plus  = (ch == CH_PLUS);
  assign is_mul   = (ch == CH_MUL);
  // '0'..'9' are 0x30..0x39, so the low nibble is the digit value.
  assign digit    = ch[3:0];
`ifdef EXPR_SUB_EN
  assign is_minus = (ch == CH_MINUS);
`else
  assign is_minus = 1'b0;
`endif
endmodule

// File: rtl/expr_eval.sv
// Streaming recogniser/evaluator for "operand (op operand)*" with '*' binding tighter than '+'.
// Define EXPR_SUB_EN to accept '-' as an operator with '+' precedence.
module expr_eval
  import expr_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int MAX_DIGITS = 4
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [7:0]       in,
  input  logic             in_valid,
  output logic             out,
  output logic [WIDTH-1:0] value,
  output logic             err
);
  localparam int NDW = $clog2(MAX_DIGITS + 1);
  localparam logic [NDW-1:0] NDIG_MAX = NDW'(MAX_DIGITS);

  logic             is_digit, is_plus, is_mul, is_minus;
  logic [3:0]       digit;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sum_q, sum_d, term_q, term_d, num_q, num_d, value_q, value_d;
  logic [NDW-1:0]   ndig_q, ndig_d;
  logic             out_q, out_d, err_q, err_d;

  expr_char_class u_class (
    .ch       (in),
    .is_digit (is_digit),
    .is_plus  (is_plus),
    .is_mul   (is_mul),
    .is_minus (is_minus),
    .digit    (digit)
  );

  always_comb begin
    state_d = state_q;
    sum_d   = sum_q;
    term_d  = term_q;
    num_d   = num_q;
    ndig_d  = ndig_q;
    out_d   = out_q;
    err_d   = err_q;
    value_d = value_q;
    if (in_valid) begin
      unique case (state_q)
        S_IDLE, S_OP: begin
          if (is_digit) begin
            state_d = S_NUM;
            num_d   = WIDTH'(digit);
            ndig_d  = NDW'(1);
          end else begin
            state_d = S_ERR;
          end
        end
        S_NUM: begin
          if (is_digit) begin
            if (ndig_q == NDIG_MAX) begin
              state_d = S_ERR;
            end else begin
              num_d  = num_q * WIDTH'(10) + WIDTH'(digit);
              ndig_d = ndig_q + NDW'(1);
            end
          end else if (is_plus) begin
            state_d = S_OP;
            sum_d   = sum_q + term_q * num_q;
            term_d  = WIDTH'(1);
            num_d   = '0;
            ndig_d  = '0;
          end else if (is_mul) begin
            state_d = S_OP;
            term_d  = term_q * num_q;
            num_d   = '0;
            ndig_d  = '0;
`ifdef EXPR_SUB_EN
          end else if (is_minus) begin
            // The next term carries the sign: a -1 multiplier folds negation into the product.
            state_d = S_OP;
            sum_d   = sum_q + term_q * num_q;
            term_d  = '1;
            num_d   = '0;
            ndig_d  = '0;
`else
          end else if (is_minus) begin
            state_d = S_ERR;
`endif
          end else begin
            state_d = S_ERR;
          end
        end
        default: state_d = S_ERR;
      endcase
      out_d   = (state_d == S_NUM);
      err_d   = (state_d == S_ERR);
      value_d = out_d ? (sum_d + term_d * num_d) : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= S_IDLE;
      sum_q   <= '0;
      term_q  <= WIDTH'(1);
      num_q   <= '0;
      ndig_q  <= '0;
      out_q   <= 1'b0;
      err_q   <= 1'b0;
      value_q <= '0;
    end else begin
      state_q <= state_d;
      sum_q   <= sum_d;
      term_q  <= term_d;
      num_q   <= num_d;
      ndig_q  <= ndig_d;
      out_q   <= out_d;
      err_q   <= err_d;
      value_q <= value_d;
    end
  end

  assign out   = out_q;
  assign value = value_q;
  assign err   = err_q;
endmodule
